// File: rtl/linebuf_scheduler_if.sv
// rtl/linebuf_scheduler_if.sv - writer/reader handshake bundle for the line buffer scheduler
interface linebuf_scheduler_if;
  logic       wr_commit;
  logic       greenflag;
  logic       rd_ready;
  logic       rd_start;
  logic [2:0] rd_line;
  logic       rd_done;
  logic       rd_abort;
  logic [3:0] occupancy;
  logic       overflow_err;

  modport master (
    output wr_commit, rd_ready, rd_done,
    input  greenflag, rd_start, rd_line, rd_abort, occupancy, overflow_err
  );

  modport slave (
    input  wr_commit, rd_ready, rd_done,
    output greenflag, rd_start, rd_line, rd_abort, occupancy, overflow_err
  );
endinterface

// File: rtl/linebuf_scheduler.sv
// rtl/linebuf_scheduler.sv - ring occupancy tracker and read sequencer with watchdog
// Counts committed lines, gates the writer via greenflag and hands lines to the reader in order.
module linebuf_scheduler #(
  parameter int LINES      = 8,
  parameter int RD_GAP     = 2,
  parameter int RD_TIMEOUT = 4096
) (
  input logic               clk,
  input logic               rst,
  linebuf_scheduler_if.slave bus
);

  localparam logic [3:0]  LINES_C  = 4'(LINES);
  localparam logic [3:0]  GAP_LAST = (RD_GAP == 0) ? 4'd0 : 4'(RD_GAP - 1);
  localparam logic [15:0] WD_LAST  = 16'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] wd_q, wd_d;
  logic        greenflag_q, greenflag_d;
  logic        rd_start_q, rd_start_d;
  logic        rd_abort_q, rd_abort_d;
  logic [2:0]  rd_line_q, rd_line_d;
  logic        overflow_q, overflow_d;
  logic        release_w;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    gap_d      = gap_q;
    wd_d       = wd_q;
    rd_line_d  = rd_line_q;
    overflow_d = overflow_q;
    rd_start_d = 1'b0;
    rd_abort_d = 1'b0;
    release_w  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != 4'd0 && bus.rd_ready) begin
          state_d    = S_START;
          rd_start_d = 1'b1;
          rd_line_d  = rd_ptr_q;
        end
      end
      S_START: begin
        state_d = S_BUSY;
        wd_d    = 16'd0;
      end
      S_BUSY: begin
        // A done arriving on the expiry cycle wins, so no abort is raised.
        if (bus.rd_done) begin
          release_w = 1'b1;
        end else if (wd_q == WD_LAST) begin
          release_w  = 1'b1;
          rd_abort_d = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
        if (release_w) begin
          rd_ptr_d = rd_ptr_q + 3'd1;
          gap_d    = 4'd0;
          state_d  = (RD_GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    case ({bus.wr_commit, release_w})
      2'b10: begin
        if (count_q == LINES_C) overflow_d = 1'b1;
        else                    count_d    = count_q + 4'd1;
      end
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    greenflag_d = (count_d < LINES_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= 4'd0;
      rd_ptr_q    <= 3'd0;
      gap_q       <= 4'd0;
      wd_q        <= 16'd0;
      greenflag_q <= 1'b0;
      rd_start_q  <= 1'b0;
      rd_abort_q  <= 1'b0;
      rd_line_q   <= 3'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      gap_q       <= gap_d;
      wd_q        <= wd_d;
      greenflag_q <= greenflag_d;
      rd_start_q  <= rd_start_d;
      rd_abort_q  <= rd_abort_d;
      rd_line_q   <= rd_line_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.greenflag    = greenflag_q;
  assign bus.rd_start     = rd_start_q;
  assign bus.rd_abort     = rd_abort_q;
  assign bus.rd_line      = rd_line_q;
  assign bus.occupancy    = count_q;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_linebuf_scheduler.sv
// tb/tb_linebuf_scheduler.sv - scenario tasks with an in-order rd_line scoreboard
module tb_linebuf_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] wr_idx = 3'd0;

  linebuf_scheduler_if bus();

  linebuf_scheduler #(.LINES(8), .RD_GAP(2), .RD_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every rd_start must present the oldest committed, not-yet-read line.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst && bus.rd_start) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_line_order: rd_start with line %0d but no line pending", bus.rd_line);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd_line !== e) begin
          n_fail++;
          $display("FAIL rd_line_order: got %0d expected %0d", bus.rd_line, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_commit(input bit accept);
    tick();
    bus.wr_commit = 1'b1;
    if (accept) begin
      exp_q.push_back(wr_idx);
      wr_idx = wr_idx + 3'd1;
    end
    tick();
    bus.wr_commit = 1'b0;
  endtask

  task automatic wait_start();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rd_start) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_start: rd_start seen %0d expected 1 within 40 cycles", ok);
    end
  endtask

  task automatic read_one();
    wait_start();
    tick();
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    bus.wr_commit = 1'b0;
    bus.rd_done   = 1'b0;
    exp_q.delete();
    wr_idx = 3'd0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    bus.rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.greenflag, bus.rd_start, bus.rd_abort, bus.rd_line, bus.occupancy, bus.overflow_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gf=%b st=%b ab=%b line=%0d occ=%0d ovf=%b expected all 0",
               bus.greenflag, bus.rd_start, bus.rd_abort, bus.rd_line, bus.occupancy, bus.overflow_err);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.greenflag !== 1'b0) begin
      n_fail++;
      $display("FAIL greenflag_before_edge: got %b expected 0", bus.greenflag);
    end
    @(negedge clk);
    n_checks++;
    if (bus.greenflag !== 1'b1 || bus.occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL greenflag_after_reset: got gf=%b occ=%0d expected gf=1 occ=0", bus.greenflag, bus.occupancy);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rd_start) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got rd_start=%b expected 0", seen);
    end
  endtask

  task automatic test_fill();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulse_commit(1'b1);
      if (i == 6) begin
        @(negedge clk);
        n_checks++;
        if (bus.greenflag !== 1'b1 || bus.occupancy !== 4'd7) begin
          n_fail++;
          $display("FAIL fill_seven: got gf=%b occ=%0d expected gf=1 occ=7", bus.greenflag, bus.occupancy);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.greenflag !== 1'b0 || bus.occupancy !== 4'd8 || bus.overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got gf=%b occ=%0d ovf=%b expected gf=0 occ=8 ovf=0",
               bus.greenflag, bus.occupancy, bus.overflow_err);
    end
    pulse_commit(1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.overflow_err !== 1'b1 || bus.occupancy !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow: got ovf=%b occ=%0d expected ovf=1 occ=8", bus.overflow_err, bus.occupancy);
    end
  endtask

  task automatic test_reset_midop();
    bus.rd_ready = 1'b1;
    wait_start();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.greenflag, bus.rd_start, bus.rd_abort, bus.occupancy, bus.overflow_err} !== 8'd0) begin
      n_fail++;
      $display("FAIL midop_reset: got gf=%b st=%b ab=%b occ=%0d ovf=%b expected all 0",
               bus.greenflag, bus.rd_start, bus.rd_abort, bus.occupancy, bus.overflow_err);
    end
    exp_q.delete();
    wr_idx = 3'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rd_abort !== 1'b0 || bus.occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL midop_reset_hold: got ab=%b occ=%0d expected ab=0 occ=0", bus.rd_abort, bus.occupancy);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_occ;
    logic       exp_st;
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      tick();
      bus.wr_commit = (c == 0 || c == 6);
      bus.rd_done   = (c == 5 || c == 11);
      if (bus.wr_commit) begin
        exp_q.push_back(wr_idx);
        wr_idx = wr_idx + 3'd1;
      end
      @(negedge clk);
      exp_occ = ((c >= 1 && c <= 5) || (c >= 7 && c <= 11)) ? 4'd1 : 4'd0;
      exp_st  = (c == 2 || c == 9);
      n_checks++;
      if (bus.occupancy !== exp_occ || bus.rd_start !== exp_st) begin
        n_fail++;
        $display("FAIL single_c%0d: got occ=%0d st=%b expected occ=%0d st=%b",
                 c, bus.occupancy, bus.rd_start, exp_occ, exp_st);
      end
    end
    tick();
    bus.wr_commit = 1'b0;
    bus.rd_done   = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] max_occ = 4'd0;
    bus.rd_ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      pulse_commit(1'b1);
      if (bus.occupancy > max_occ) max_occ = bus.occupancy;
      wait_start();
      if (bus.occupancy > max_occ) max_occ = bus.occupancy;
      tick();
      bus.rd_done = 1'b1;
      tick();
      bus.rd_done = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.occupancy !== 4'd0) begin
        n_fail++;
        $display("FAIL wrap_drain_%0d: got occ=%0d expected 0", p, bus.occupancy);
      end
    end
    n_checks++;
    if (max_occ !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_max_occ: got %0d expected 1", max_occ);
    end
  endtask

  task automatic test_simul();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse_commit(1'b1);
    bus.rd_ready = 1'b1;
    wait_start();
    tick();
    bus.wr_commit = 1'b1;
    bus.rd_done   = 1'b1;
    exp_q.push_back(wr_idx);
    wr_idx = wr_idx + 3'd1;
    tick();
    bus.wr_commit = 1'b0;
    bus.rd_done   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.occupancy !== 4'd3 || bus.greenflag !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_commit_done: got occ=%0d gf=%b expected occ=3 gf=1", bus.occupancy, bus.greenflag);
    end
    for (int i = 0; i < 3; i++) read_one();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL simul_drain: got occ=%0d expected 0", bus.occupancy);
    end
  endtask

  task automatic test_watchdog();
    bus.rd_ready = 1'b1;
    pulse_commit(1'b1);
    wait_start();
    for (int b = 1; b <= 16; b++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rd_abort !== 1'b0) begin
        n_fail++;
        $display("FAIL wd_early_abort_b%0d: got %b expected 0", b, bus.rd_abort);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.rd_abort !== 1'b1 || bus.occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL wd_abort: got ab=%b occ=%0d expected ab=1 occ=0", bus.rd_abort, bus.occupancy);
    end
    tick();
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rd_abort !== 1'b0 || bus.occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL wd_late_done: got ab=%b occ=%0d expected ab=0 occ=0", bus.rd_abort, bus.occupancy);
    end
    // Done on the very cycle the watchdog would expire.
    pulse_commit(1'b1);
    wait_start();
    repeat (16) tick();
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rd_abort !== 1'b0 || bus.occupancy !== 4'd0) begin
        n_fail++;
        $display("FAIL wd_done_at_expiry_%0d: got ab=%b occ=%0d expected ab=0 occ=0",
                 i, bus.rd_abort, bus.occupancy);
      end
    end
  endtask

  initial begin
    bus.wr_commit = 1'b0;
    bus.rd_ready  = 1'b0;
    bus.rd_done   = 1'b0;
    test_reset();
    test_fill();
    test_reset_midop();
    apply_reset();
    test_single();
    apply_reset();
    test_wrap();
    test_simul();
    test_watchdog();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_lines: got %0d unread expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
